// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer:
// per-channel FSM encoding and the counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } dbn_state_e;

  // Width of a counter able to hold the largest of the three periods.
  function automatic int calc_cnt_w(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/multi_button_debouncer_if.sv
// Bus between raw board buttons / control and the debouncer.
// There is no valid/ready handshake: btn_in and repeat_en are sampled on
// every clock edge, btn_level is a level, and press/release/long pulses
// are single-cycle strobes that are valid exactly in the cycle they are high.
// dbg_state carries each channel's 2-bit FSM state, channel g at [2g+1:2g].
interface multi_button_debouncer_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   btn_in;
  logic [NUM_CH-1:0]   repeat_en;
  logic [NUM_CH-1:0]   btn_level;
  logic [NUM_CH-1:0]   press_pulse;
  logic [NUM_CH-1:0]   release_pulse;
  logic [NUM_CH-1:0]   long_pulse;
  logic [2*NUM_CH-1:0] dbg_state;

  modport master (
    output btn_in, repeat_en,
    input  btn_level, press_pulse, release_pulse, long_pulse, dbg_state
  );

  modport slave (
    input  btn_in, repeat_en,
    output btn_level, press_pulse, release_pulse, long_pulse, dbg_state
  );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: polarity fix, 2-flop synchroniser, stability-based
// debounce FSM with hold (long-press) and auto-repeat counters.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int LONG_CYCLES     = 40000000,
  parameter int REPEAT_CYCLES   = 8000000,
  parameter int ACTIVE_LOW_IN   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  input  logic       repeat_en_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [1:0] state_o
);

  localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RMAX = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic INV = (ACTIVE_LOW_IN != 0);

  logic       sync1_q, sync2_q, s;
  dbn_state_e state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d, rcnt_q, rcnt_d;
  logic long_done_q, long_done_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d, long_q, long_d;

  assign s = sync2_q;

  // State register: synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      rcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_i ^ INV;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      rcnt_q      <= rcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Next state and counters; hold/repeat counts freeze in RELEASE_WAIT.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    rcnt_d      = rcnt_q;
    long_done_d = long_done_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DMAX) begin
          state_d     = HELD;
          dcnt_d      = '0;
          hcnt_d      = '0;
          rcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (!long_done_q) begin
          if (hcnt_q == LMAX) begin
            long_done_d = 1'b1;
            hcnt_d      = '0;
            rcnt_d      = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (repeat_en_i) begin
          rcnt_d = (rcnt_q == RMAX) ? '0 : rcnt_q + 1'b1;
        end else begin
          rcnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          dcnt_d  = '0;
        end else if (dcnt_q == DMAX) begin
          state_d     = IDLE;
          dcnt_d      = '0;
          hcnt_d      = '0;
          rcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: pulses default low, level changes only on accepted edges.
  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: level_d = 1'b0;
      PRESS_WAIT: begin
        if (s && dcnt_q == DMAX) begin
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (s && !long_done_q && hcnt_q == LMAX) long_d = 1'b1;
        if (s && long_done_q && repeat_en_i && rcnt_q == RMAX) press_d = 1'b1;
      end
      RELEASE_WAIT: begin
        if (!s && dcnt_q == DMAX) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: level_d = 1'b0;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign state_o   = state_q;

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent button channels, each a debounce_channel instance.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int LONG_CYCLES     = 40000000,
  parameter int REPEAT_CYCLES   = 8000000,
  parameter int ACTIVE_LOW_IN   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_button_debouncer_if.slave  bus
);

  logic [NUM_CH-1:0]   level_w, press_w, release_w, long_w;
  logic [2*NUM_CH-1:0] state_w;

  // One fully independent conditioner per button.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
    ) u_ch (
      .clk         (clk),
      .rst         (reset),
      .btn_i       (bus.btn_in[g]),
      .repeat_en_i (bus.repeat_en[g]),
      .level_o     (level_w[g]),
      .press_o     (press_w[g]),
      .release_o   (release_w[g]),
      .long_o      (long_w[g]),
      .state_o     (state_w[2*g +: 2])
    );
  end

  assign bus.btn_level     = level_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;
  assign bus.long_pulse    = long_w;
  assign bus.dbg_state     = state_w;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer: expected pulse events
// {kind, channel, edge number} are queued when stimulus is driven and
// popped by a monitor whenever the DUT emits a pulse.
module tb_multi_button_debouncer;

  localparam int NUM_CH = 2;
  localparam int DEB    = 4;
  localparam int LNG    = 20;
  localparam int RPT    = 8;
  localparam int LAT    = DEB + 3;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  multi_button_debouncer_if #(.NUM_CH(NUM_CH)) bus ();

  multi_button_debouncer #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (RPT),
    .ACTIVE_LOW_IN   (0)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and edge counter (cyc = number of rising edges so far).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(int kind, int ch, int c);
    return {4'(kind), 4'(ch), 24'(c)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(int ch, logic v);
    bus.btn_in[ch] = v;
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = K_PRESS; k <= K_LONG; k++) begin
        logic p;
        p = (k == K_PRESS) ? bus.press_pulse[ch] :
            (k == K_REL)   ? bus.release_pulse[ch] : bus.long_pulse[ch];
        if (p === 1'b1) begin
          if (exp_q.size() == 0) check("unexpected_pulse", ev(k, ch, cyc), 32'hFFFF_FFFF);
          else                   check("pulse_event", ev(k, ch, cyc), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int t0;
    int p;
    int tr;
    reset         = 1'b1;
    bus.btn_in    = '0;
    bus.repeat_en = '0;
    wait_cyc(3);
    check("rst_level",   32'(bus.btn_level), 32'd0);
    check("rst_press",   32'(bus.press_pulse), 32'd0);
    check("rst_release", 32'(bus.release_pulse), 32'd0);
    check("rst_long",    32'(bus.long_pulse), 32'd0);
    check("rst_state",   32'(bus.dbg_state), 32'd0);
    reset = 1'b0;
    wait_cyc(3);

    // Clean press/release on ch0; ch1 must stay quiet.
    set_btn(0, 1'b1); t0 = cyc;
    exp_q.push_back(ev(K_PRESS, 0, t0 + LAT));
    wait_cyc(10);
    check("t1_level0_held", 32'(bus.btn_level[0]), 32'd1);
    check("t1_level1_idle", 32'(bus.btn_level[1]), 32'd0);
    set_btn(0, 1'b0); t0 = cyc;
    exp_q.push_back(ev(K_REL, 0, t0 + LAT));
    wait_cyc(12);
    check("t1_level0_rel", 32'(bus.btn_level[0]), 32'd0);
    check("t1_level1_end", 32'(bus.btn_level[1]), 32'd0);

    // Short high glitches of 1, 2 and 3 cycles on ch0.
    for (int w = 1; w <= 3; w++) begin
      set_btn(0, 1'b1); wait_cyc(w);
      set_btn(0, 1'b0); wait_cyc(3);
    end
    wait_cyc(10);
    check("t2_level0", 32'(bus.btn_level[0]), 32'd0);
    check("t2_state0", 32'(bus.dbg_state[1:0]), 32'd0);

    // Long hold on ch1 without repeat.
    set_btn(1, 1'b1); t0 = cyc;
    exp_q.push_back(ev(K_PRESS, 1, t0 + LAT));
    exp_q.push_back(ev(K_LONG, 1, t0 + LAT + LNG));
    wait_cyc(40);
    check("t3_level1_held", 32'(bus.btn_level[1]), 32'd1);
    set_btn(1, 1'b0);
    exp_q.push_back(ev(K_REL, 1, cyc + LAT));
    wait_cyc(12);
    check("t3_level1_rel", 32'(bus.btn_level[1]), 32'd0);

    // Hold on ch1 with auto-repeat, repeat_en dropped at press+38.
    bus.repeat_en[1] = 1'b1;
    set_btn(1, 1'b1); t0 = cyc; p = t0 + LAT;
    exp_q.push_back(ev(K_PRESS, 1, p));
    exp_q.push_back(ev(K_LONG,  1, p + LNG));
    exp_q.push_back(ev(K_PRESS, 1, p + LNG + RPT));
    exp_q.push_back(ev(K_PRESS, 1, p + LNG + 2 * RPT));
    wait_cyc(p + 38 - cyc);
    bus.repeat_en[1] = 1'b0;
    wait_cyc(5);
    check("t4_level1_held", 32'(bus.btn_level[1]), 32'd1);
    set_btn(1, 1'b0);
    exp_q.push_back(ev(K_REL, 1, cyc + LAT));
    wait_cyc(12);
    check("t4_level1_rel", 32'(bus.btn_level[1]), 32'd0);

    // 2-cycle low glitch while ch0 is held: 3 frozen hold cycles.
    set_btn(0, 1'b1); t0 = cyc; p = t0 + LAT;
    exp_q.push_back(ev(K_PRESS, 0, p));
    exp_q.push_back(ev(K_LONG,  0, p + LNG + 3));
    wait_cyc(12);
    set_btn(0, 1'b0); wait_cyc(2);
    set_btn(0, 1'b1); wait_cyc(6);
    check("t5_level0_after_glitch", 32'(bus.btn_level[0]), 32'd1);
    wait_cyc(20);
    set_btn(0, 1'b0);
    exp_q.push_back(ev(K_REL, 0, cyc + LAT));
    wait_cyc(12);
    check("t5_level0_rel", 32'(bus.btn_level[0]), 32'd0);

    // Reset mid-PRESS_WAIT (dcnt=2), then mid-HELD.
    set_btn(0, 1'b1);
    wait_cyc(5);
    check("t6_state_pw", 32'(bus.dbg_state[1:0]), 32'd1);
    reset = 1'b1; #1;
    check("t6_rst1_state", 32'(bus.dbg_state), 32'd0);
    check("t6_rst1_level", 32'(bus.btn_level), 32'd0);
    wait_cyc(3);
    reset = 1'b0; tr = cyc;
    exp_q.push_back(ev(K_PRESS, 0, tr + LAT));
    wait_cyc(12);
    check("t6_level_held", 32'(bus.btn_level[0]), 32'd1);
    check("t6_state_held", 32'(bus.dbg_state[1:0]), 32'd2);
    reset = 1'b1; #1;
    check("t6_rst2_level", 32'(bus.btn_level), 32'd0);
    check("t6_rst2_state", 32'(bus.dbg_state), 32'd0);
    check("t6_rst2_press", 32'(bus.press_pulse), 32'd0);
    wait_cyc(2);
    reset = 1'b0; tr = cyc;
    exp_q.push_back(ev(K_PRESS, 0, tr + LAT));
    wait_cyc(10);
    set_btn(0, 1'b0);
    exp_q.push_back(ev(K_REL, 0, cyc + LAT));
    wait_cyc(12);
    check("t6_level_end", 32'(bus.btn_level), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
